// File: rtl/mult_share_pkg.sv
// Shared constants for the time-shared multiplier scheduler: operand/product
// widths, FSM state encodings and the requester-id width helper.
package mult_share_pkg;

    localparam int OP_W = 16;
    localparam int P_W  = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mult16bit.sv
// Purely combinational 16x16 unsigned array multiplier; the scheduler holds its
// inputs stable for several clocks, so it is timed as a multicycle path.
module mult16bit
    import mult_share_pkg::*;
(
    input  logic [OP_W-1:0] a,
    input  logic [OP_W-1:0] b,
    output logic [P_W-1:0]  p
);

    assign p = {{(P_W-OP_W){1'b0}}, a} * {{(P_W-OP_W){1'b0}}, b};

endmodule

// File: rtl/mult_share_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or above ptr,
// wrapping around, and reports it as one-hot, as an index and as "any".
module rr_arbiter
    import mult_share_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  idx,
    output logic             any
);

    always_comb begin
        int j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/mult_share_sched.sv
// Shares one mult16bit among N_REQ requesters via round-robin arbitration and
// valid/ready handshakes. Define MULT_OUT_REG_EN to register the multiplier output.
module mult_share_sched
    import mult_share_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int MULT_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ*16-1:0]           req_a,
    input  logic [N_REQ*16-1:0]           req_b,
    output logic [N_REQ-1:0]              req_ready,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [31:0]                   rsp_p,
    output logic [id_width(N_REQ)-1:0]    rsp_id,
    output logic                          busy
);

    localparam int ID_W = id_width(N_REQ);
`ifdef MULT_OUT_REG_EN
    localparam int CNT_INIT = MULT_CYCLES;
`else
    localparam int CNT_INIT = MULT_CYCLES - 1;
`endif
    localparam int CNT_W = (CNT_INIT < 2) ? 1 : $clog2(CNT_INIT + 1);

    logic [1:0]       state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [OP_W-1:0]  op_a_q, op_a_d;
    logic [OP_W-1:0]  op_b_q, op_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [P_W-1:0]   rsp_p_q, rsp_p_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;

    logic [N_REQ-1:0] gnt_onehot;
    logic [ID_W-1:0]  gnt_idx;
    logic             gnt_any;
    logic [P_W-1:0]   mult_p;
    logic [P_W-1:0]   mult_p_sel;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (gnt_onehot),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    mult16bit u_mult (
        .a (op_a_q),
        .b (op_b_q),
        .p (mult_p)
    );

`ifdef MULT_OUT_REG_EN
    // Operands are stable from the accepting edge, so every sample of p_reg
    // taken during CALC already holds the final product.
    logic [P_W-1:0] p_reg_q, p_reg_d;
    assign p_reg_d = mult_p;
    always_ff @(posedge clk) begin
        p_reg_q <= p_reg_d;
    end
    assign mult_p_sel = p_reg_q;
`else
    assign mult_p_sel = mult_p;
`endif

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        cnt_d    = cnt_q;
        rsp_p_d  = rsp_p_q;
        rsp_id_d = rsp_id_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    op_a_d   = req_a[OP_W*int'(gnt_idx) +: OP_W];
                    op_b_d   = req_b[OP_W*int'(gnt_idx) +: OP_W];
                    rsp_id_d = gnt_idx;
                    cnt_d    = CNT_W'(CNT_INIT);
                    rr_ptr_d = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    state_d  = ST_CALC;
                end
            end
            ST_CALC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    rsp_p_d = mult_p_sel;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // Returning to IDLE first keeps a bubble before the next accept.
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            cnt_q    <= '0;
            rsp_p_q  <= '0;
            rsp_id_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            cnt_q    <= cnt_d;
            rsp_p_q  <= rsp_p_d;
            rsp_id_q <= rsp_id_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE) ? gnt_onehot : '0;
    assign rsp_valid = (state_q == ST_HOLD);
    assign busy      = (state_q == ST_CALC) || (state_q == ST_HOLD);
    assign rsp_p     = rsp_p_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_mult_share_sched.sv
// Directed bench for mult_share_sched: two instances (MULT_CYCLES=2 and 1)
// with hand-computed products, grant order and latencies.
module tb_mult_share_sched;

    localparam int N = 4;
`ifdef MULT_OUT_REG_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int LAT1 = 2 + EXTRA;
    localparam int LAT2 = 1 + EXTRA;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [N-1:0]  req_valid, req_ready;
    logic [N*16-1:0] req_a, req_b;
    logic          rsp_valid, rsp_ready, busy;
    logic [31:0]   rsp_p;
    logic [1:0]    rsp_id;

    logic [N-1:0]  req_valid2, req_ready2;
    logic [N*16-1:0] req_a2, req_b2;
    logic          rsp_valid2, rsp_ready2, busy2;
    logic [31:0]   rsp_p2;
    logic [1:0]    rsp_id2;

    int checks = 0;
    int failures = 0;

    mult_share_sched #(.N_REQ(N), .MULT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_p(rsp_p), .rsp_id(rsp_id), .busy(busy)
    );

    mult_share_sched #(.N_REQ(N), .MULT_CYCLES(1)) dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid2), .req_a(req_a2), .req_b(req_b2),
        .req_ready(req_ready2), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2),
        .rsp_p(rsp_p2), .rsp_id(rsp_id2), .busy(busy2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_port(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        #1;
        while (req_ready == '0 && n < 20) begin
            tick();
            n++;
        end
        chk("ready_wait_bound", 32'(n < 20), 32'd1);
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic do_op(input int id, input logic [31:0] p);
        int n;
        wait_ready();
        chk($sformatf("grant_%0d", id), 32'(req_ready), 32'(1 << id));
        tick();
        chk("ready_low_calc", 32'(req_ready), 32'd0);
        chk("busy_calc", 32'(busy), 32'd1);
        wait_rsp(n);
        chk("latency", 32'(n), 32'(LAT1));
        chk($sformatf("rsp_p_%0d", id), rsp_p, p);
        chk($sformatf("rsp_id_%0d", id), 32'(rsp_id), 32'(id));
        tick();
        chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        req_valid2 = '0; req_a2 = '0; req_b2 = '0; rsp_ready2 = 1'b0;
        tick();
        tick();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_p", rsp_p, 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_busy2", 32'(busy2), 32'd0);
        rst = 1'b0;

        // Single op on port 0
        set_port(0, 16'h0081, 16'h00FF);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        do_op(0, 32'h0000807F);
        req_valid = '0;

        // All ports valid: round-robin order 0,1,2,3,0
        do_reset();
        set_port(0, 16'h0003, 16'h0005);
        set_port(1, 16'h1234, 16'h0010);
        set_port(2, 16'hFFFF, 16'h0002);
        set_port(3, 16'h8000, 16'h8000);
        req_valid = 4'b1111;
        do_op(0, 32'h0000000F);
        do_op(1, 32'h00012340);
        do_op(2, 32'h0001FFFE);
        do_op(3, 32'h40000000);
        do_op(0, 32'h0000000F);
        req_valid = '0;

        // Max operands with consumer stalled for 5 cycles
        do_reset();
        set_port(2, 16'hFFFF, 16'hFFFF);
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        wait_ready();
        chk("stall_grant", 32'(req_ready), 32'h4);
        tick();
        wait_rsp(n);
        chk("stall_latency", 32'(n), 32'(LAT1));
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_p", rsp_p, 32'hFFFE0001);
            chk("stall_id", 32'(rsp_id), 32'd2);
            chk("stall_ready", 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        req_valid = '0;
        tick();
        chk("stall_release", 32'(rsp_valid), 32'd0);

        // Reset in the middle of CALC discards the op and restarts rr_ptr at 0
        do_reset();
        set_port(1, 16'h00CC, 16'h00AA);
        set_port(3, 16'h0011, 16'h0003);
        req_valid = 4'b0010;
        wait_ready();
        chk("midrst_grant", 32'(req_ready), 32'h2);
        tick();
        chk("midrst_busy", 32'(busy), 32'd1);
        tick();
        rst = 1'b1;
        req_valid = '0;
        tick();
        chk("midrst_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_busy_clr", 32'(busy), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        req_valid = 4'b1010;
        do_op(1, 32'h00008778);
        do_op(3, 32'h00000033);
        req_valid = '0;

        // MULT_CYCLES=1 instance
        set_port(3, 16'h0000, 16'h0000);
        req_a2[48 +: 16] = 16'h00C0;
        req_b2[48 +: 16] = 16'h0007;
        req_valid2 = 4'b1000;
        rsp_ready2 = 1'b1;
        #1;
        chk("mc1_grant", 32'(req_ready2), 32'h8);
        tick();
        req_valid2 = '0;
        n = 0;
        while (!rsp_valid2 && n < 50) begin
            tick();
            n++;
        end
        chk("mc1_latency", 32'(n), 32'(LAT2));
        chk("mc1_p", rsp_p2, 32'h00000540);
        chk("mc1_id", 32'(rsp_id2), 32'd3);
        tick();
        chk("mc1_drop", 32'(rsp_valid2), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
